// File: rtl/core_boot_sequencer.sv
// Boot sequencer: streams a program into IRAM, pulses core reset, runs the core for a
// programmed number of cycles, then streams DRAM words out for inspection.
//   state    | meaning
//   IDLE     | waiting for start, core held in reset
//   LOAD     | accepting program words into IRAM
//   CORE_RST | core reset pulse, RESET_CYCLES long
//   RUN      | core clock enabled for run_cycles (or until halt)
//   DUMP     | streaming DRAM words 0..DUMP_WORDS-1
//   DONE     | core frozen, waiting for a new start
module core_boot_sequencer #(
  parameter int IRAM_DEPTH   = 16,
  parameter int IRAM_AW      = 4,
  parameter int DRAM_AW      = 8,
  parameter int DUMP_WORDS   = 8,
  parameter int RESET_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CNT_W-1:0]   run_cycles,
  input  logic               halt,
  input  logic               load_valid,
  input  logic [31:0]        load_data,
  input  logic               load_last,
  output logic               load_ready,
  output logic               iram_write,
  output logic [IRAM_AW-1:0] iram_select,
  output logic [31:0]        iram_data,
  output logic               core_rst,
  output logic               core_clk_en,
  output logic [DRAM_AW-1:0] dram_select,
  input  logic [31:0]        dram_read_data,
  output logic               dump_valid,
  output logic [31:0]        dump_data,
  input  logic               dump_ready,
  output logic               busy,
  output logic               done,
  output logic               overflow
);

  localparam int RC_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [IRAM_AW-1:0] LAST_IDX  = IRAM_AW'(IRAM_DEPTH - 1);
  localparam logic [DRAM_AW-1:0] LAST_DUMP = DRAM_AW'(DUMP_WORDS - 1);
  localparam logic [RC_W-1:0]    RC_INIT   = RC_W'(RESET_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CORE_RST, S_RUN, S_DUMP, S_DONE
  } state_t;

  state_t state, state_next;

  logic [IRAM_AW-1:0] load_idx;
  logic [CNT_W-1:0]   run_cnt;
  logic [RC_W-1:0]    rst_cnt;
  logic               load_fire;
  logic               load_end;
  logic               dump_fire;

  assign load_fire = (state == S_LOAD) && load_valid;
  assign load_end  = load_fire && (load_last || (load_idx == LAST_IDX));
  assign dump_fire = dump_valid && dump_ready;

  assign load_ready  = (state == S_LOAD);
  assign core_rst    = (state == S_IDLE) || (state == S_LOAD) || (state == S_CORE_RST);
  assign core_clk_en = (state == S_RUN);
  assign busy        = (state != S_IDLE) && (state != S_DONE);
  assign done        = (state == S_DONE);
  assign dump_data   = dram_read_data;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_next = S_LOAD;
      S_LOAD:         if (load_end) state_next = S_CORE_RST;
      S_CORE_RST: begin
        if (rst_cnt == '0) state_next = (run_cnt == '0) ? S_DUMP : S_RUN;
      end
      // the cycle in which halt is sampled is still an enabled core cycle
      S_RUN:  if (halt || (run_cnt == CNT_W'(1))) state_next = S_DUMP;
      S_DUMP: if (dump_fire && (dram_select == LAST_DUMP)) state_next = S_DONE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      iram_write  <= 1'b0;
      iram_select <= '0;
      iram_data   <= '0;
      dram_select <= '0;
      dump_valid  <= 1'b0;
      overflow    <= 1'b0;
      load_idx    <= '0;
      run_cnt     <= '0;
      rst_cnt     <= '0;
    end else begin
      iram_write <= 1'b0;
      if (state != S_DUMP) begin
        dram_select <= '0;
        dump_valid  <= 1'b0;
      end
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            run_cnt  <= run_cycles;
            load_idx <= '0;
            overflow <= 1'b0;
          end
        end
        S_LOAD: begin
          if (load_fire) begin
            iram_write  <= 1'b1;
            iram_select <= load_idx;
            iram_data   <= load_data;
            load_idx    <= load_idx + IRAM_AW'(1);
            if ((load_idx == LAST_IDX) && !load_last) overflow <= 1'b1;
          end
          if (load_end) rst_cnt <= RC_INIT;
        end
        S_CORE_RST: if (rst_cnt != '0) rst_cnt <= rst_cnt - RC_W'(1);
        S_RUN:      run_cnt <= run_cnt - CNT_W'(1);
        S_DUMP: begin
          // one settle cycle with dump_valid low after entry and after every transfer
          if (dump_fire) begin
            dump_valid <= 1'b0;
            if (dram_select != LAST_DUMP) dram_select <= dram_select + DRAM_AW'(1);
          end else begin
            dump_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
